// File: rtl/enb_ctrl_if.sv
// Control/status bundle for enb_ctrl: burst request inputs and enable/status outputs.
interface enb_ctrl_if;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic [3:0] div;
    logic       enb;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    modport master (
        output start,
        output stop,
        output count,
        output div,
        input  enb,
        input  busy,
        input  done,
        input  remaining
    );

    modport slave (
        input  start,
        input  stop,
        input  count,
        input  div,
        output enb,
        output busy,
        output done,
        output remaining
    );
endinterface

// File: rtl/enb_ctrl.sv
// Burst clock-enable generator: issues 'count' enable pulses spaced div+1 cycles apart,
// with the final enable re-registered on the falling edge so eclk = clk & enb never glitches.
module enb_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    enb_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     r_state;
    logic       r_enb_pre;
    logic [7:0] r_remaining;
    logic [3:0] r_div_cnt;
    logic [3:0] r_div;
    logic       r_enb;

    state_e     w_state_nxt;
    logic       w_enb_pre_nxt;
    logic [7:0] w_remaining_nxt;
    logic [3:0] w_div_cnt_nxt;
    logic [3:0] w_div_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_enb_pre   <= 1'b0;
            r_remaining <= 8'd0;
            r_div_cnt   <= 4'd0;
            r_div       <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_enb_pre   <= w_enb_pre_nxt;
            r_remaining <= w_remaining_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_div       <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_enb_pre_nxt   = 1'b0;
        w_remaining_nxt = r_remaining;
        w_div_cnt_nxt   = r_div_cnt;
        w_div_nxt       = r_div;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.count != 8'd0) begin
                        w_remaining_nxt = bus.count;
                        w_div_cnt_nxt   = 4'd0;
                        w_div_nxt       = bus.div;
                        w_state_nxt     = StRun;
                    end else begin
                        w_state_nxt     = StDone;
                    end
                end
            end
            StRun: begin
                // Abort wins over pulse generation; remaining is frozen for inspection.
                if (bus.stop) begin
                    w_state_nxt = StDone;
                end else if (r_div_cnt == 4'd0) begin
                    w_enb_pre_nxt = 1'b1;
                    w_div_cnt_nxt = r_div;
                    if (r_remaining != 8'd0) begin
                        w_remaining_nxt = r_remaining - 8'd1;
                    end
                    if (r_remaining <= 8'd1) begin
                        w_state_nxt = StDone;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 4'd1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Falling-edge copy keeps enb constant across the entire clk-high phase.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_enb <= 1'b0;
        end else begin
            r_enb <= r_enb_pre;
        end
    end

    assign bus.enb       = r_enb;
    assign bus.busy      = (r_state == StRun);
    assign bus.done      = (r_state == StDone);
    assign bus.remaining = r_remaining;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.done));
    a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);

endmodule
